// File: rtl/imem_fetch_port_pkg.sv
// Shared constants and types for the instruction-memory fetch responder.
package imem_fetch_port_pkg;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          PKT_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Packet returned when no ROM word is valid in a slot.
   function automatic logic [PKT_W-1:0] nop_pkt();
      return {NOP, NOP};
   endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake between the fetch stage (master) and
// the instruction-memory responder (slave).
interface imem_fetch_port_if
   import imem_fetch_port_pkg::*;
#(
   parameter int ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ADDR_W-1:0] rsp_addr;
   logic [PKT_W-1:0]  rsp_inst;
   logic [1:0]        rsp_slot_valid;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_addr, rsp_inst, rsp_slot_valid, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_addr, rsp_inst, rsp_slot_valid, rsp_err
   );

endinterface

// File: rtl/imem_fetch_port_addr_chk.sv
// Combinational request address decode: ROM word index, range/alignment
// error and "last ROM word" flag.
module imem_addr_chk #(
   parameter int              ADDR_W    = 32,
   parameter int              MEM_WORDS = 4096,
   parameter int              ROM_AW    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [ROM_AW-1:0] word,
   output logic              bad,
   output logic              last
);

   localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(MEM_WORDS);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_WORDS - 1);

   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] word_full;

   assign off       = addr - BASE_ADDR;
   assign word_full = off >> 2;

   // The full-width word index is compared so that addresses far beyond the
   // ROM are not aliased back into range by truncation.
   assign bad  = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (word_full >= DEPTH);
   assign last = (word_full == LAST_WORD);
   assign word = word_full[ROM_AW-1:0];

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction-memory responder: reads two consecutive ROM words per fetch
// request and returns them as one {inst1, inst0} packet.
module imem_fetch_port
   import imem_fetch_port_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                MEM_WORDS = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   localparam int               ROM_AW    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   imem_fetch_port_if.slave  bus,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data
);

   state_e              state_q, state_d;
   logic [ROM_AW-1:0]   word_q;
   logic                last_q;
   logic [ADDR_W-1:0]   rsp_addr_q;
   logic [PKT_W-1:0]    rsp_inst_q;
   logic [1:0]          slot_q;
   logic                err_q;

   logic [ROM_AW-1:0]   chk_word;
   logic                chk_bad;
   logic                chk_last;
   logic                ready;
   logic                accept;

   imem_addr_chk #(
      .ADDR_W    (ADDR_W),
      .MEM_WORDS (MEM_WORDS),
      .ROM_AW    (ROM_AW),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_chk (
      .addr (bus.req_addr),
      .word (chk_word),
      .bad  (chk_bad),
      .last (chk_last)
   );

   assign ready  = !flush && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
   assign accept = bus.req_valid && ready;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         state_q <= state_d;
      end
   end

   // Next-state and ROM read control.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d  = state_q;
      rom_en   = 1'b0;
      rom_addr = chk_word;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               state_d = chk_bad ? RESP : BEAT0;
               rom_en  = !chk_bad;
            end else if (state_q == RESP && bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         BEAT0: begin
            if (last_q) begin
               state_d = RESP;
            end else begin
               state_d  = BEAT1;
               rom_en   = 1'b1;
               rom_addr = word_q + 1'b1;
            end
         end
         BEAT1:   state_d = RESP;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Response datapath: cleared at accept, filled as ROM words return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q     <= '0;
         last_q     <= 1'b0;
         rsp_addr_q <= '0;
         rsp_inst_q <= nop_pkt();
         slot_q     <= 2'b00;
         err_q      <= 1'b0;
      end else if (accept) begin
         word_q     <= chk_word;
         last_q     <= chk_last;
         rsp_addr_q <= bus.req_addr;
         rsp_inst_q <= nop_pkt();
         slot_q     <= 2'b00;
         err_q      <= chk_bad;
      end else if (state_q == BEAT0) begin
         rsp_inst_q[31:0] <= rom_data;
         if (last_q) slot_q <= 2'b01;
      end else if (state_q == BEAT1) begin
         rsp_inst_q[63:32] <= rom_data;
         slot_q            <= 2'b11;
      end
   end

   assign bus.req_ready      = ready;
   assign bus.rsp_valid      = (state_q == RESP);
   assign bus.rsp_addr       = rsp_addr_q;
   assign bus.rsp_inst       = rsp_inst_q;
   assign bus.rsp_slot_valid = slot_q;
   assign bus.rsp_err        = err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port with a 16-word ROM model.
module tb_imem_fetch_port;
   import imem_fetch_port_pkg::*;

   localparam int MEM_WORDS = 16;
   localparam int ROM_AW    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_data = '0;
   logic [31:0]       rom [MEM_WORDS];
   int                rom_pulses = 0;
   int                checks = 0;
   int                failures = 0;

   imem_fetch_port_if #(.ADDR_W(32)) bus ();

   imem_fetch_port #(
      .ADDR_W    (32),
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .bus      (bus),
      .rom_en   (rom_en),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model plus read-pulse counter.
   always @(posedge clk) begin
      if (rom_en) begin
         rom_data   <= rom[rom_addr];
         rom_pulses <= rom_pulses + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Accept at the current negedge, wait for rsp_valid, check the packet,
   // then confirm the retire on the following cycle.
   task automatic run_fetch(input string tag, input logic [31:0] addr, input int exp_lat,
                            input logic [63:0] exp_inst, input logic [1:0] exp_slot,
                            input logic exp_err, input int exp_pulses);
      int lat;
      int p0;
      p0 = rom_pulses;
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      #1;
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_inst"}, bus.rsp_inst, exp_inst);
      check({tag, "_slot"}, 64'(bus.rsp_slot_valid), 64'(exp_slot));
      check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
      check({tag, "_addr"}, 64'(bus.rsp_addr), 64'(addr));
      check({tag, "_rom_pulses"}, 64'(rom_pulses - p0), 64'(exp_pulses));
      @(negedge clk);
      check({tag, "_retired"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      int lat;
      int seen;
      for (int i = 0; i < MEM_WORDS; i++) rom[i] = 32'h1000_0000 | i;
      rom[0]  = 32'h0050_0093;
      rom[1]  = 32'h00A0_0113;
      rom[2]  = 32'h00F0_0193;
      rom[3]  = 32'h0140_0213;
      rom[15] = 32'h0000_0073;

      reset         = 1'b0;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b1;

      // Reset values.
      @(negedge clk);
      check("rst_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_err", 64'(bus.rsp_err), 64'd0);
      check("rst_slot", 64'(bus.rsp_slot_valid), 64'd0);
      check("rst_addr", 64'(bus.rsp_addr), 64'd0);
      check("rst_inst", bus.rsp_inst, 64'h00000013_00000013);
      check("rst_rom_en", 64'(rom_en), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Full pair, last word, misaligned, out of range.
      run_fetch("pair0", 32'h0, 3, 64'h00A00113_00500093, 2'b11, 1'b0, 2);
      run_fetch("last", 32'h3C, 2, 64'h00000013_00000073, 2'b01, 1'b0, 1);
      run_fetch("misal", 32'h2, 1, 64'h00000013_00000013, 2'b00, 1'b1, 0);
      run_fetch("range", 32'h40, 1, 64'h00000013_00000013, 2'b00, 1'b1, 0);

      // Back-pressure: response held, then retire + accept in one cycle.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("hold_latency", 64'(lat), 64'd3);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 64'(bus.rsp_valid), 64'd1);
         check("hold_inst", bus.rsp_inst, 64'h00A00113_00500093);
         check("hold_req_ready", 64'(bus.req_ready), 64'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8;
      #1;
      check("b2b_req_ready", 64'(bus.req_ready), 64'd1);
      check("b2b_rom_en", 64'(rom_en), 64'd1);
      check("b2b_rom_addr", 64'(rom_addr), 64'd2);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("b2b_valid_drop", 64'(bus.rsp_valid), 64'd0);
      lat = 1;
      while (!bus.rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", 64'(lat), 64'd3);
      check("b2b_inst", bus.rsp_inst, 64'h01400213_00F00193);
      @(negedge clk);

      // Flush in BEAT0 discards the fetch.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      flush = 1'b1;
      bus.req_valid = 1'b1;
      #1;
      check("flush_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      bus.req_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.rsp_valid) seen++;
         @(negedge clk);
      end
      check("flush_no_rsp", 64'(seen), 64'd0);
      run_fetch("after_flush", 32'h4, 3, 64'h00F00193_00A00113, 2'b11, 1'b0, 2);

      // Reset during BEAT1.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h4;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      check("mid_rst_addr", 64'(bus.rsp_addr), 64'd0);
      check("mid_rst_inst", bus.rsp_inst, 64'h00000013_00000013);
      check("mid_rst_slot", 64'(bus.rsp_slot_valid), 64'd0);
      check("mid_rst_rom_en", 64'(rom_en), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.rsp_valid) seen++;
         @(negedge clk);
      end
      check("mid_rst_no_rsp", 64'(seen), 64'd0);
      run_fetch("after_rst", 32'h0, 3, 64'h00A00113_00500093, 2'b11, 1'b0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
